// File: rtl/sqrt_pkg.sv
// Shared parameters, FSM state type and exponent-shift helper for the
// digit-recurrence square-root core.
package sqrt_pkg;

    localparam int unsigned X_W    = 26;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned LZ_ONE = 6;
    localparam int unsigned CNT_W  = $clog2(X_W);
    localparam int unsigned REM_W  = X_W + 2;
    localparam int unsigned RAD_W  = 2 * X_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Half-exponent of the result. The reduction stage applied an even
    // shift k; the root needs k/2, positive when the operand was scaled
    // up (small leading-zero count) and negative when scaled down.
    function automatic logic [EXP_W-1:0] calc_shift(
        input logic [EXP_W-1:0] exp_f,
        input logic [EXP_W-1:0] exp_f1
    );
        logic [EXP_W:0]   k;
        logic [EXP_W-1:0] half;
        logic [EXP_W-1:0] result;
        k      = '0;
        half   = '0;
        result = '0;
        if (exp_f1 < EXP_W'(LZ_ONE)) begin
            k      = {1'b0, exp_f} + (EXP_W+1)'(exp_f[0]);
            half   = EXP_W'(k >> 1);
            result = half;
        end else if (exp_f1 == EXP_W'(LZ_ONE)) begin
            result = '0;
        end else begin
            k      = {1'b0, exp_f} - (EXP_W+1)'(exp_f[0]);
            half   = EXP_W'(k >> 1);
            result = -half;
        end
        return result;
    endfunction

endpackage

// File: rtl/sqrt_digit_recurrence_if.sv
// Operand and result handshake bundle of the square-root core.
// The core attaches through the slave modport, the producer/consumer
// side through the master modport.
interface sqrt_digit_recurrence_if;
    import sqrt_pkg::*;

    // operand channel
    logic             iValid;
    logic             oReady;
    logic [X_W-1:0]   iX_f;
    logic [EXP_W-1:0] iExp_f;
    logic [EXP_W-1:0] iExp_f1;

    // result channel
    logic             oValid;
    logic             iReady;
    logic [X_W-1:0]   oRoot;
    logic             oRem_nz;
    logic [EXP_W-1:0] oShift;

    modport slave (
        input  iValid,
        input  iX_f,
        input  iExp_f,
        input  iExp_f1,
        input  iReady,
        output oReady,
        output oValid,
        output oRoot,
        output oRem_nz,
        output oShift
    );

    modport master (
        output iValid,
        output iX_f,
        output iExp_f,
        output iExp_f1,
        output iReady,
        input  oReady,
        input  oValid,
        input  oRoot,
        input  oRem_nz,
        input  oShift
    );

endinterface

// File: rtl/sqrt_digit_step.sv
// One restoring square-root recurrence step: brings down two radicand
// bits, tries to subtract (4*root + 1) and produces the next root bit.
module sqrt_digit_step
    import sqrt_pkg::*;
(
    input  logic [REM_W-1:0] rem_i,
    input  logic [X_W-1:0]   root_i,
    input  logic [1:0]       bits_i,
    output logic [REM_W-1:0] rem_o,
    output logic [X_W-1:0]   root_o
);

    logic [REM_W+1:0] acc;
    logic [REM_W+1:0] sub;
    logic [REM_W+1:0] trial;

    // Trial subtraction; keep it when non-negative, otherwise restore.
    // The remainder is bounded by 2*root, so truncation to REM_W is exact.
    always_comb begin
        acc   = {rem_i, bits_i};
        sub   = {2'b00, root_i, 2'b01};
        trial = acc - sub;
        if (acc >= sub) begin
            rem_o  = REM_W'(trial);
            root_o = X_W'({root_i, 1'b1});
        end else begin
            rem_o  = REM_W'(acc);
            root_o = X_W'({root_i, 1'b0});
        end
    end

endmodule

// File: rtl/sqrt_digit_recurrence.sv
// Iterative square-root core: floor(sqrt(X_f * 2^X_W)) one root bit per
// clock by restoring digit recurrence, plus the signed half-exponent
// shift for later denormalisation. One operation in flight at a time.
module sqrt_digit_recurrence
    import sqrt_pkg::*;
(
    input logic                      iClk,
    input logic                      iRst_n,
    sqrt_digit_recurrence_if.slave   bus
);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RAD_W-1:0]  rad_q;
    logic [REM_W-1:0]  rem_q;
    logic [X_W-1:0]    root_q;
    logic [EXP_W-1:0]  shift_q;

    logic              ready_q;
    logic              valid_q;
    logic [X_W-1:0]    root_out_q;
    logic              rem_nz_q;
    logic [EXP_W-1:0]  shift_out_q;

    logic [REM_W-1:0]  rem_d;
    logic [X_W-1:0]    root_d;

    sqrt_digit_step u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (rad_q[RAD_W-1 -: 2]),
        .rem_o  (rem_d),
        .root_o (root_d)
    );

    // Control FSM, recurrence datapath and registered result outputs.
    // The first DONE cycle loads the result registers and raises oValid;
    // retirement on iReady is only possible once oValid is visible.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            shift_q     <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            root_out_q  <= '0;
            rem_nz_q    <= 1'b0;
            shift_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iValid && ready_q) begin
                        rad_q   <= {bus.iX_f, {X_W{1'b0}}};
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= CNT_W'(X_W - 1);
                        shift_q <= calc_shift(bus.iExp_f, bus.iExp_f1);
                        ready_q <= 1'b0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!valid_q) begin
                        root_out_q  <= root_q;
                        rem_nz_q    <= (rem_q != '0);
                        shift_out_q <= shift_q;
                        valid_q     <= 1'b1;
                    end else if (bus.iReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oReady  = ready_q;
    assign bus.oValid  = valid_q;
    assign bus.oRoot   = root_out_q;
    assign bus.oRem_nz = rem_nz_q;
    assign bus.oShift  = shift_out_q;

endmodule

// File: tb/tb_sqrt_digit_recurrence.sv
// Directed bench for sqrt_digit_recurrence with hand-computed results.
module tb_sqrt_digit_recurrence;
    import sqrt_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sqrt_digit_recurrence_if bus ();

    sqrt_digit_recurrence u_dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operand, wait for acceptance, then count clocks to oValid.
    task automatic run_op(input logic [25:0] x, input logic [5:0] e,
                          input logic [5:0] e1, output int lat);
        int n;
        bus.iX_f    = x;
        bus.iExp_f  = e;
        bus.iExp_f1 = e1;
        bus.iValid  = 1'b1;
        n = 0;
        while (!bus.oReady && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        lat = 0;
        while (!bus.oValid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic retire();
        bus.iReady = 1'b1;
        @(posedge clk); #1;
        bus.iReady = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.iValid  = 1'b0;
        bus.iReady  = 1'b0;
        bus.iX_f    = '0;
        bus.iExp_f  = '0;
        bus.iExp_f1 = '0;
        #12;
        checks += 5;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.oReady); end
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.oValid); end
        if (bus.oRoot !== 26'h0) begin errors++; $display("FAIL reset_root: got %h expected 0", bus.oRoot); end
        if (bus.oRem_nz !== 1'b0) begin errors++; $display("FAIL reset_remnz: got %b expected 0", bus.oRem_nz); end
        if (bus.oShift !== 6'h0) begin errors++; $display("FAIL reset_shift: got %h expected 0", bus.oShift); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_quarter();
        int lat;
        run_op(26'h1000000, 6'd0, 6'd6, lat);
        checks += 4;
        if (lat != 27) begin errors++; $display("FAIL quarter_latency: got %0d expected 27", lat); end
        if (bus.oRoot !== 26'h2000000) begin errors++; $display("FAIL quarter_root: got %h expected 2000000", bus.oRoot); end
        if (bus.oRem_nz !== 1'b0) begin errors++; $display("FAIL quarter_remnz: got %b expected 0", bus.oRem_nz); end
        if (bus.oShift !== 6'h00) begin errors++; $display("FAIL quarter_shift: got %h expected 00", bus.oShift); end
        retire();
    endtask

    task automatic test_half();
        int lat;
        run_op(26'h2000000, 6'd3, 6'd2, lat);
        checks += 4;
        if (lat != 27) begin errors++; $display("FAIL half_latency: got %0d expected 27", lat); end
        if (bus.oRoot !== 26'h2D413CC) begin errors++; $display("FAIL half_root: got %h expected 2d413cc", bus.oRoot); end
        if (bus.oRem_nz !== 1'b1) begin errors++; $display("FAIL half_remnz: got %b expected 1", bus.oRem_nz); end
        if (bus.oShift !== 6'h02) begin errors++; $display("FAIL half_shift: got %h expected 02", bus.oShift); end
        retire();
    endtask

    task automatic test_boundaries();
        int lat;
        run_op(26'h0, 6'd0, 6'd6, lat);
        checks += 2;
        if (bus.oRoot !== 26'h0) begin errors++; $display("FAIL zero_root: got %h expected 0", bus.oRoot); end
        if (bus.oRem_nz !== 1'b0) begin errors++; $display("FAIL zero_remnz: got %b expected 0", bus.oRem_nz); end
        retire();
        run_op(26'h3FFFFFF, 6'd0, 6'd6, lat);
        checks += 2;
        if (bus.oRoot !== 26'h3FFFFFF) begin errors++; $display("FAIL ones_root: got %h expected 3ffffff", bus.oRoot); end
        if (bus.oRem_nz !== 1'b1) begin errors++; $display("FAIL ones_remnz: got %b expected 1", bus.oRem_nz); end
        retire();
    endtask

    task automatic test_shift();
        int lat;
        run_op(26'h1000000, 6'd5, 6'd10, lat);
        checks++;
        if (bus.oShift !== 6'h3E) begin errors++; $display("FAIL shift_5_10: got %h expected 3e", bus.oShift); end
        retire();
        run_op(26'h1000000, 6'd4, 6'd9, lat);
        checks++;
        if (bus.oShift !== 6'h3E) begin errors++; $display("FAIL shift_4_9: got %h expected 3e", bus.oShift); end
        retire();
        run_op(26'h1000000, 6'd7, 6'd3, lat);
        checks++;
        if (bus.oShift !== 6'h04) begin errors++; $display("FAIL shift_7_3: got %h expected 04", bus.oShift); end
        retire();
        run_op(26'h1000000, 6'd9, 6'd6, lat);
        checks++;
        if (bus.oShift !== 6'h00) begin errors++; $display("FAIL shift_9_6: got %h expected 00", bus.oShift); end
        retire();
    endtask

    task automatic test_hold();
        int lat;
        run_op(26'h2000000, 6'd3, 6'd2, lat);
        for (int i = 0; i < 10; i++) begin
            bus.iValid = (i % 2 == 0);
            bus.iX_f   = 26'h0;
            @(posedge clk); #1;
            checks += 3;
            if (bus.oValid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus.oValid); end
            if (bus.oRoot !== 26'h2D413CC) begin errors++; $display("FAIL hold_root[%0d]: got %h expected 2d413cc", i, bus.oRoot); end
            if (bus.oReady !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, bus.oReady); end
        end
        bus.iValid = 1'b0;
        retire();
        run_op(26'h1000000, 6'd0, 6'd6, lat);
        checks += 2;
        if (lat != 27) begin errors++; $display("FAIL hold_next_latency: got %0d expected 27", lat); end
        if (bus.oRoot !== 26'h2000000) begin errors++; $display("FAIL hold_next_root: got %h expected 2000000", bus.oRoot); end
        retire();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(26'h3FFFFFF, 6'd0, 6'd6, lat);
        bus.iReady  = 1'b1;
        bus.iX_f    = 26'h2000000;
        bus.iExp_f  = 6'd3;
        bus.iExp_f1 = 6'd2;
        bus.iValid  = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL b2b_retired: got %b expected 0", bus.oValid); end
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", bus.oReady); end
        bus.iReady = 1'b0;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        checks++;
        if (bus.oReady !== 1'b0) begin errors++; $display("FAIL b2b_accepted: got %b expected 0", bus.oReady); end
        lat = 0;
        while (!bus.oValid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        checks += 3;
        if (lat != 27) begin errors++; $display("FAIL b2b_latency: got %0d expected 27", lat); end
        if (bus.oRoot !== 26'h2D413CC) begin errors++; $display("FAIL b2b_root: got %h expected 2d413cc", bus.oRoot); end
        if (bus.oShift !== 6'h02) begin errors++; $display("FAIL b2b_shift: got %h expected 02", bus.oShift); end
        retire();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        bus.iX_f    = 26'h2000000;
        bus.iExp_f  = 6'd3;
        bus.iExp_f1 = 6'd2;
        bus.iValid  = 1'b1;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.oReady); end
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.oValid); end
        if (bus.oRoot !== 26'h0) begin errors++; $display("FAIL midrst_root: got %h expected 0", bus.oRoot); end
        if (bus.oRem_nz !== 1'b0) begin errors++; $display("FAIL midrst_remnz: got %b expected 0", bus.oRem_nz); end
        if (bus.oShift !== 6'h0) begin errors++; $display("FAIL midrst_shift: got %h expected 0", bus.oShift); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.oValid) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_spurious_valid: got %b expected 0", seen); end
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b expected 1", bus.oReady); end
        run_op(26'h1000000, 6'd0, 6'd6, lat);
        checks += 2;
        if (lat != 27) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 27", lat); end
        if (bus.oRoot !== 26'h2000000) begin errors++; $display("FAIL midrst_next_root: got %h expected 2000000", bus.oRoot); end
        retire();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_quarter();
        test_half();
        test_boundaries();
        test_shift();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
